// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe -- three-stage pipelined IEEE754 add/subtract unit.
//
// Stages: S1 align (unpack, specials, swap, right-shift with G/R/S),
//         S2 add (magnitude add or subtract),
//         S3 normalise + round (registered into the output).
// One global advance signal stalls every stage at once, so in_ready is
// simply "output register is free or being drained this cycle".
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake; in_op (opADD=0, opSUB=1, else -> 0)
//   in_a, in_b         operands {sign, exp, frac}
//   out_valid/out_ready result handshake
//   out_result         a+b or a-b
//   out_flags          {invalid, overflow, underflow, inexact}
//
// Build option: FPU_ROUND_NEAREST_EN selects round-to-nearest-even; when it is
// undefined the result is truncated and G/R/S only drive the inexact flag.
module fpu_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  // Working mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int MW  = FRAC_W + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = EXP_W + 2;
  localparam logic [EXP_W-1:0]    EXP_MAX = '1;
  localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic adv;
  logic out_valid_q;
  logic [W-1:0] out_result_q;
  logic [3:0]   out_flags_q;

  assign adv        = !out_valid_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // ---------------- S1: unpack, specials, align ----------------
  logic              sub_op, op_ok, sa, sb, nan_a, nan_b, inf_a, inf_b, a_big;
  logic [EXP_W-1:0]  ea, eb, e_small, diff;
  logic [FRAC_W:0]   ma, mb, m_small;
  logic [MW-1:0]     ext_small;
  logic              s1_sp_d, s1_sign_big_d, s1_sign_small_d;
  logic [W-1:0]      s1_sp_res_d;
  logic [3:0]        s1_sp_flags_d;
  logic [EXP_W-1:0]  s1_exp_d;
  logic [MW-1:0]     s1_mbig_d, s1_msmall_d;

  always_comb begin
    sub_op = (in_op == OP_SUB);
    op_ok  = (in_op == OP_ADD) || sub_op;
    sa     = in_a[W-1];
    sb     = in_b[W-1] ^ sub_op;       // subtraction = addition of negated b
    ea     = in_a[W-2:FRAC_W];
    eb     = in_b[W-2:FRAC_W];
    nan_a  = (ea == EXP_MAX) && (in_a[FRAC_W-1:0] != '0);
    nan_b  = (eb == EXP_MAX) && (in_b[FRAC_W-1:0] != '0);
    inf_a  = (ea == EXP_MAX) && (in_a[FRAC_W-1:0] == '0);
    inf_b  = (eb == EXP_MAX) && (in_b[FRAC_W-1:0] == '0);
    // Denormals are flushed: a zero exponent yields a zero mantissa.
    ma     = (ea != '0) ? {1'b1, in_a[FRAC_W-1:0]} : '0;
    mb     = (eb != '0) ? {1'b1, in_b[FRAC_W-1:0]} : '0;
    // Keeping the larger magnitude first means S2 never goes negative.
    a_big  = {ea, ma} >= {eb, mb};

    s1_sign_big_d   = a_big ? sa : sb;
    s1_sign_small_d = a_big ? sb : sa;
    s1_exp_d        = a_big ? ea : eb;
    e_small         = a_big ? eb : ea;
    m_small         = a_big ? mb : ma;
    s1_mbig_d       = {(a_big ? ma : mb), 3'b000};
    diff            = s1_exp_d - e_small;
    ext_small       = {m_small, 3'b000};

    if (32'(diff) >= 32'(MW - 1)) begin
      s1_msmall_d = {{(MW-1){1'b0}}, |m_small};
    end else begin
      // Bits shifted past the sticky position are ORed back into it.
      s1_msmall_d = (ext_small >> diff)
                  | {{(MW-1){1'b0}}, |(ext_small & ~({MW{1'b1}} << diff))};
    end

    s1_sp_d       = 1'b0;
    s1_sp_res_d   = '0;
    s1_sp_flags_d = 4'b0000;
    if (!op_ok) begin
      s1_sp_d = 1'b1;
    end else if (nan_a || nan_b) begin
      s1_sp_d     = 1'b1;
      s1_sp_res_d = QNAN;
    end else if (inf_a && inf_b && (sa != sb)) begin
      s1_sp_d       = 1'b1;
      s1_sp_res_d   = QNAN;
      s1_sp_flags_d = 4'b1000;
    end else if (inf_a) begin
      s1_sp_d     = 1'b1;
      s1_sp_res_d = {sa, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (inf_b) begin
      s1_sp_d     = 1'b1;
      s1_sp_res_d = {sb, EXP_MAX, {FRAC_W{1'b0}}};
    end
  end

  logic              s1_valid_q, s1_sp_q, s1_sign_big_q, s1_sign_small_q;
  logic [W-1:0]      s1_sp_res_q;
  logic [3:0]        s1_sp_flags_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [MW-1:0]     s1_mbig_q, s1_msmall_q;

  // ---------------- S2: magnitude add / subtract ----------------
  logic [MW:0] s2_sum_d;
  logic        s2_zsign_d;

  always_comb begin
    if (s1_sign_big_q != s1_sign_small_q)
      s2_sum_d = {1'b0, s1_mbig_q} - {1'b0, s1_msmall_q};
    else
      s2_sum_d = {1'b0, s1_mbig_q} + {1'b0, s1_msmall_q};
    // Exact zero is -0 only when both addends were negative.
    s2_zsign_d = s1_sign_big_q & s1_sign_small_q;
  end

  logic              s2_valid_q, s2_sp_q, s2_sign_q, s2_zsign_q;
  logic [W-1:0]      s2_sp_res_q;
  logic [3:0]        s2_sp_flags_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [MW:0]       s2_sum_q;

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]          lzc;
  logic [MW-1:0]           norm;
  logic signed [XW-1:0]    exp_n, exp_r;
  logic                    g_bit, r_bit, s_bit, round_up, inexact;
  logic [FRAC_W+1:0]       mant_r;
  logic [FRAC_W-1:0]       frac_r;
  logic [W-1:0]            out_result_d;
  logic [3:0]              out_flags_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < MW; i++) begin
      if (s2_sum_q[i]) lzc = LZW'(MW - 1 - i);
    end

    if (s2_sum_q[MW]) begin
      norm  = {s2_sum_q[MW:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = $signed({2'b00, s2_exp_q}) + XW'(1);
    end else begin
      norm  = s2_sum_q[MW-1:0] << lzc;
      exp_n = $signed({2'b00, s2_exp_q}) - $signed({{(XW-LZW){1'b0}}, lzc});
    end

    g_bit   = norm[2];
    r_bit   = norm[1];
    s_bit   = norm[0];
    inexact = g_bit | r_bit | s_bit;
`ifdef FPU_ROUND_NEAREST_EN
    round_up = g_bit && (r_bit || s_bit || norm[3]);
`else
    round_up = 1'b0;
`endif
    mant_r = {1'b0, norm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, round_up};
    if (mant_r[FRAC_W+1]) begin
      exp_r  = exp_n + XW'(1);
      frac_r = mant_r[FRAC_W:1];
    end else begin
      exp_r  = exp_n;
      frac_r = mant_r[FRAC_W-1:0];
    end

    if (s2_sp_q) begin
      out_result_d = s2_sp_res_q;
      out_flags_d  = s2_sp_flags_q;
    end else if (s2_sum_q == '0) begin
      out_result_d = {s2_zsign_q, {(W-1){1'b0}}};
      out_flags_d  = 4'b0000;
    end else if (exp_r >= EXP_OVF) begin
      out_result_d = {s2_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
      out_flags_d  = 4'b0101;
    end else if (exp_r <= 0) begin
      out_result_d = {s2_sign_q, {(W-1){1'b0}}};
      out_flags_d  = 4'b0011;
    end else begin
      out_result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
      out_flags_d  = {3'b000, inexact};
    end
  end

  // Control: valid bits and output register, reset-cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= 4'b0000;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_result_q <= out_result_d;
        out_flags_q  <= out_flags_d;
      end
    end
  end

  // Datapath registers: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sp_q         <= s1_sp_d;
      s1_sp_res_q     <= s1_sp_res_d;
      s1_sp_flags_q   <= s1_sp_flags_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_exp_q        <= s1_exp_d;
      s1_mbig_q       <= s1_mbig_d;
      s1_msmall_q     <= s1_msmall_d;
      s2_sp_q         <= s1_sp_q;
      s2_sp_res_q     <= s1_sp_res_q;
      s2_sp_flags_q   <= s1_sp_flags_q;
      s2_sign_q       <= s1_sign_big_q;
      s2_zsign_q      <= s2_zsign_d;
      s2_exp_q        <= s1_exp_q;
      s2_sum_q        <= s2_sum_d;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed testbench for fpu_addsub_pipe (EXP_W=8, FRAC_W=23).
module tb_fpu_addsub_pipe;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [31:0] ONE   = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One operation on an otherwise idle pipe with out_ready held high.
  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    #1;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, ".early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".result"}, out_result, exp_res);
    check_eq({tag, ".flags"}, 32'(out_flags), 32'(exp_flags));
  endtask

  logic [31:0] bp_a   [6];
  logic [31:0] bp_exp [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, rcvd, cyc;
    logic stalled_prev, drop_seen;
    logic [31:0] prev_res;

    bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    rst = 1'b1; in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.out_valid", 32'(out_valid), 32'd0);
    check_eq("reset.out_result", out_result, 32'h0);
    check_eq("reset.out_flags", 32'(out_flags), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset.in_ready", 32'(in_ready), 32'd1);

    run_vec("add_1_1",    OP_ADD, ONE,          ONE,          32'h40000000, 4'b0000);
    run_vec("sub_eq",     OP_SUB, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 4'b0000);
    run_vec("neg0_neg0",  OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
    run_vec("overflow",   OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
    run_vec("inf_m_inf",  OP_SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
`ifdef FPU_ROUND_NEAREST_EN
    run_vec("round_up",   OP_ADD, ONE,          32'h33C00000, 32'h3F800001, 4'b0001);
`else
    run_vec("round_up",   OP_ADD, ONE,          32'h33C00000, 32'h3F800000, 4'b0001);
`endif
    run_vec("round_tie",  OP_ADD, ONE,          32'h33800000, 32'h3F800000, 4'b0001);
    run_vec("inf_p_1",    OP_ADD, 32'h7F800000, ONE,          32'h7F800000, 4'b0000);
    run_vec("nan_p_1",    OP_ADD, 32'h7FC00001, ONE,          32'h7FC00000, 4'b0000);
    run_vec("underflow",  OP_SUB, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011);
    run_vec("sub_2_1",    OP_SUB, 32'h40000000, ONE,          ONE,          4'b0000);
    run_vec("add_1_m2",   OP_ADD, ONE,          32'hC0000000, 32'hBF800000, 4'b0000);
    run_vec("sub_1_m1",   OP_SUB, ONE,          32'hBF800000, 32'h40000000, 4'b0000);
    run_vec("bad_op",     3'b111, ONE,          ONE,          32'h00000000, 4'b0000);

    // Let the last result drain.
    @(posedge clk); #1;

    // Backpressure: six back-to-back adds, consumer stalled for the first 8 cycles.
    sent = 0; rcvd = 0; cyc = 0; stalled_prev = 1'b0; drop_seen = 1'b0; prev_res = '0;
    while (rcvd < 6 && cyc < 60) begin
      out_ready = (cyc >= 8);
      if (sent < 6) begin
        in_valid = 1'b1; in_op = OP_ADD; in_a = bp_a[sent]; in_b = ONE;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        check_eq("bp.hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp.hold_result", out_result, prev_res);
      end
      if (!drop_seen && out_valid && !out_ready) begin
        drop_seen = 1'b1;
        check_eq("bp.in_ready_drop", 32'(in_ready), 32'd0);
        check_eq("bp.held_beats", 32'(sent), 32'd3);
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("bp.result%0d", rcvd), out_result, bp_exp[rcvd]);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      prev_res = out_result;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bp.received", 32'(rcvd), 32'd6);
    check_eq("bp.stall_seen", 32'(drop_seen), 32'd1);
    @(posedge clk); #1;
    check_eq("bp.no_extra", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_a = ONE; in_b = ONE;
    @(posedge clk); #1;
    in_a = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("midrst.idle%0d", i), 32'(out_valid), 32'd0);
    end

    // Pipe still works after the mid-stream reset.
    run_vec("post_rst",   OP_ADD, ONE,          ONE,          32'h40000000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
